// File: rtl/bus_sync_ctrl.sv
// Destination-side controller for a toggle req/ack bus crossing into clk.
// Optional parity checking is enabled with `define BUS_SYNC_PARITY_EN.
module bus_sync_ctrl #(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req_tgl_in,
   input  logic [WIDTH-1:0] data_in,
`ifdef BUS_SYNC_PARITY_EN
   input  logic             par_in,
   output logic             parity_err,
`endif
   output logic             ack_tgl_out,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t     state, state_nxt;
   logic       req_s1, req_s2, req_seen;
   logic [3:0] settle_cnt;
   logic       pending;
   logic       seen_ld, cnt_clr, cnt_inc, capture, complete;

   assign pending = req_s2 ^ req_seen;
   assign busy    = (state != IDLE);

   // Stage 0: enable-gated two-flop request synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_s1 <= 1'b0;
         req_s2 <= 1'b0;
      end else if (en) begin
         req_s1 <= req_tgl_in;
         req_s2 <= req_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      seen_ld   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               state_nxt = SETTLE;
               seen_ld   = 1'b1;
               cnt_clr   = 1'b1;
            end
         end
         SETTLE: begin
            if (en) begin
               if (settle_cnt == SETTLE_LAST) begin
                  capture   = 1'b1;
                  state_nxt = PRESENT;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         PRESENT: begin
            if (data_ready) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage 1: settle counter, capture and handshake return
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_seen    <= 1'b0;
         settle_cnt  <= 4'd0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         ack_tgl_out <= 1'b0;
         xfer_cnt    <= '0;
      end else begin
         if (seen_ld) req_seen <= req_s2;
         if (cnt_clr)      settle_cnt <= 4'd0;
         else if (cnt_inc) settle_cnt <= settle_cnt + 4'd1;
         if (capture) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
         end
         if (complete) begin
            data_valid  <= 1'b0;
            ack_tgl_out <= ~ack_tgl_out;
            xfer_cnt    <= xfer_cnt + 1'b1;
         end
      end
   end

   // A new toggle arriving while a word is in flight is kept pending, only flagged
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              overrun <= 1'b0;
      else if ((state != IDLE) && pending)  overrun <= 1'b1;
   end

`ifdef BUS_SYNC_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          par_q <= 1'b0;
      else if (capture) par_q <= par_in;
   end

   assign parity_err = data_valid & ((^data_out) ^ par_q);
`endif

endmodule

// File: tb/tb_bus_sync_ctrl.sv
// Self-checking bench for bus_sync_ctrl: vector table, randomized transfers
// against a rule-level latency model, and hand-written corner sequences.
module tb_bus_sync_ctrl;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          req_tgl_in;
   logic [W-1:0]  data_in;
   logic          ack_tgl_out;
   logic [W-1:0]  data_out;
   logic          data_valid;
   logic          data_ready;
   logic          busy;
   logic          overrun;
   logic [CW-1:0] xfer_cnt;
`ifdef BUS_SYNC_PARITY_EN
   logic          par_in;
   logic          parity_err;
`endif

   bus_sync_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_tgl_in (req_tgl_in),
      .data_in    (data_in),
`ifdef BUS_SYNC_PARITY_EN
      .par_in     (par_in),
      .parity_err (parity_err),
`endif
      .ack_tgl_out(ack_tgl_out),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .overrun    (overrun),
      .xfer_cnt   (xfer_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         per;
      int         delay;
      int         exp_rise;
      int         exp_ack;
      logic [7:0] exp_data;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[5];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;
   logic en_pat[0:255];
   logic par_flip = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic r);
      en         = e;
      data_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Edges after the toggle until data_valid: two en edges to synchronize,
   // one unconditional edge to leave IDLE, then S en edges of settling.
   function automatic int model_rise();
      int n = 0;
      int entry = 0;
      for (int i = 1; i < 256; i++) begin
         if (entry == 0) begin
            if (n == 2) begin
               entry = i;
               n = 0;
            end else if (en_pat[i]) begin
               n++;
            end
         end else if (en_pat[i]) begin
            n++;
            if (n == S) return i;
         end
      end
      return -1;
   endfunction

   task automatic xfer(input string name, input logic [7:0] d, input int delay,
                       input int exp_rise, input int exp_ack,
                       input logic [7:0] exp_d, input logic [7:0] exp_cnt);
      int         rise  = 0;
      int         ack_e = 0;
      int         bad   = 0;
      logic       ack0;
      logic [7:0] got_d = 8'h00;
      logic       perr  = 1'b0;
      ack0       = ack_tgl_out;
      data_in    = d;
`ifdef BUS_SYNC_PARITY_EN
      par_in     = (^d) ^ par_flip;
`endif
      req_tgl_in = ~req_tgl_in;
      for (int i = 1; i <= exp_ack + 2; i++) begin
         step(en_pat[i], i > exp_rise + delay);
         if (data_valid && rise == 0) begin
            rise  = i;
            got_d = data_out;
`ifdef BUS_SYNC_PARITY_EN
            perr  = parity_err;
`endif
         end
         if (ack_tgl_out !== ack0 && ack_e == 0) ack_e = i;
         if (rise != 0 && ack_e == 0 && (!data_valid || data_out !== got_d)) bad++;
      end
      n_xfer++;
      check({name, "_rise_edge"}, rise, exp_rise);
      check({name, "_data"}, got_d, exp_d);
      check({name, "_ack_edge"}, ack_e, exp_ack);
      check({name, "_hold"}, bad, 0);
      check({name, "_xfer_cnt"}, xfer_cnt, exp_cnt);
      check({name, "_idle"}, {busy, data_valid}, 2'b00);
      check({name, "_parity_err"}, perr,
`ifdef BUS_SYNC_PARITY_EN
            par_flip
`else
            1'b0
`endif
      );
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic       ack0;
      logic       prev_v;
      logic [7:0] second_d;
      int         toggles;
      int         base;

      // data, en period, backpressure, rise edge, ack edge, data, count
      vecs[0] = '{8'hA5, 1, 0,  5,  6, 8'hA5, 8'd1};
      vecs[1] = '{8'h5A, 4, 10, 16, 27, 8'h5A, 8'd2};
      vecs[2] = '{8'hC3, 2, 3,  8,  12, 8'hC3, 8'd3};
      vecs[3] = '{8'hFF, 3, 0,  12, 13, 8'hFF, 8'd4};
      vecs[4] = '{8'h00, 1, 1,  5,  7, 8'h00, 8'd5};

      rst        = 1'b1;
      en         = 1'b0;
      req_tgl_in = 1'b0;
      data_in    = '0;
      data_ready = 1'b0;
`ifdef BUS_SYNC_PARITY_EN
      par_in     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack_tgl_out, 1'b0);
      check("rst_data", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_cnt", xfer_cnt, 8'h00);
      rst = 1'b0;
      repeat (3) step(1'b1, 1'b0);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 256; i++) en_pat[i] = ((i % vecs[v].per) == 0);
         xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].delay,
              vecs[v].exp_rise, vecs[v].exp_ack, vecs[v].exp_data, vecs[v].exp_cnt);
      end

      for (int t = 0; t < 30; t++) begin
         logic [7:0] d;
         int         dly;
         int         r;
         for (int i = 0; i < 256; i++) en_pat[i] = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
         d   = 8'($urandom);
         dly = $urandom_range(0, 5);
         r   = model_rise();
         xfer($sformatf("rnd%0d", t), d, dly, r, r + dly + 1, d, 8'((n_xfer + 1) % 256));
      end

      // Second toggle while the first word is still presented
      base       = n_xfer;
      data_in    = 8'hAA;
      req_tgl_in = ~req_tgl_in;
      repeat (5) step(1'b1, 1'b0);
      check("ovr_first_valid", {data_valid, data_out}, {1'b1, 8'hAA});
      check("ovr_not_yet", overrun, 1'b0);
      ack0       = ack_tgl_out;
      data_in    = 8'h3C;
      req_tgl_in = ~req_tgl_in;
      repeat (4) step(1'b1, 1'b0);
      check("ovr_flag", overrun, 1'b1);
      check("ovr_hold_data", data_out, 8'hAA);
      check("ovr_no_ack", ack_tgl_out, ack0);
      toggles  = 0;
      second_d = 8'h00;
      prev_v   = data_valid;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1);
         if (ack_tgl_out !== ack0) toggles++;
         ack0 = ack_tgl_out;
         if (data_valid && !prev_v) second_d = data_out;
         prev_v = data_valid;
      end
      n_xfer += 2;
      check("ovr_ack_toggles", toggles, 2);
      check("ovr_second_word", second_d, 8'h3C);
      check("ovr_cnt", xfer_cnt, 8'((base + 2) % 256));
      check("ovr_sticky", overrun, 1'b1);

      // Asynchronous reset while settling
      data_in    = 8'h55;
      req_tgl_in = ~req_tgl_in;
      repeat (3) step(1'b1, 1'b0);
      check("mid_busy", {busy, data_valid}, 2'b10);
      #2;
      rst        = 1'b1;
      req_tgl_in = 1'b0;
      #1;
      check("mid_rst_valid", data_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_overrun", overrun, 1'b0);
      check("mid_rst_cnt", xfer_cnt, 8'h00);
      check("mid_rst_ack", ack_tgl_out, 1'b0);
      check("mid_rst_data", data_out, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) step(1'b1, 1'b1);
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_no_ack", ack_tgl_out, 1'b0);
      n_xfer = 0;

      for (int i = 0; i < 256; i++) en_pat[i] = 1'b1;
      for (int k = 0; k < 256; k++) begin
         xfer("wrap", 8'(k), 0, 5, 6, 8'(k), 8'((k + 1) % 256));
      end
      check("wrap_final", xfer_cnt, 8'h00);

`ifdef BUS_SYNC_PARITY_EN
      par_flip = 1'b1;
      xfer("par_bad", 8'h07, 2, 5, 8, 8'h07, 8'h01);
      par_flip = 1'b0;
      xfer("par_good", 8'h07, 0, 5, 6, 8'h07, 8'h02);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
